// File: rtl/branch_pred_unit.sv
// Fetch-stage branch predictor: BTB + bimodal/gshare PHT + circular RAS + perf counters.
// Prediction is combinational from if_pc (zero latency); training/RAS are applied at the clock edge, no backpressure.
module branch_pred_unit #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int HIST_BITS   = 8,
  parameter int MODE        = 1,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 predict_taken,
  output logic [XLEN-1:0]      predict_target,
  output logic                 target_valid,
  output logic [HIST_BITS-1:0] pred_pht_index,
  input  logic                 upd_valid,
  input  logic [XLEN-1:0]      upd_pc,
  input  logic [1:0]           upd_type,
  input  logic                 upd_taken,
  input  logic [XLEN-1:0]      upd_target,
  input  logic [HIST_BITS-1:0] upd_pht_index,
  input  logic                 upd_mispredict,
  input  logic                 ras_push,
  input  logic [XLEN-1:0]      ras_push_addr,
  input  logic                 ras_pop,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_mispredicts
);

  localparam int BI    = $clog2(BTB_ENTRIES);
  localparam int RI    = $clog2(RAS_DEPTH);
  localparam int TAG_W = XLEN - BI - 2;
  localparam int PHT_N = 1 << HIST_BITS;
  localparam logic [RI:0] RAS_FULL = (RI+1)'(RAS_DEPTH);

  typedef enum logic [1:0] {
    T_BRANCH = 2'b00,
    T_JUMP   = 2'b01,
    T_CALL   = 2'b10,
    T_RET    = 2'b11
  } ctl_type_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       kind;
  } btb_entry_t;

  btb_entry_t           btb [BTB_ENTRIES];
  logic [1:0]           pht [PHT_N];
  logic [HIST_BITS-1:0] ghr;
  logic [XLEN-1:0]      ras [RAS_DEPTH];
  logic [RI-1:0]        ras_top;
  logic [RI:0]          ras_cnt;

  logic [BI-1:0]        rd_idx;
  logic [TAG_W-1:0]     rd_tag;
  btb_entry_t           rd_entry;
  logic                 rd_hit;
  logic [HIST_BITS-1:0] pht_base;
  logic [1:0]           rd_ctr;
  logic                 ras_empty;

  logic [BI-1:0]        wr_idx;
  logic [1:0]           upd_ctr;
  logic [RI-1:0]        ras_top_inc;
  logic [RI-1:0]        ras_top_dec;
  logic                 unused_pc_lsbs;

  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  assign rd_idx         = if_pc[BI+1:2];
  assign rd_tag         = if_pc[XLEN-1:BI+2];
  assign rd_entry       = btb[rd_idx];
  assign rd_hit         = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign pht_base       = if_pc[HIST_BITS+1:2];
  assign pred_pht_index = (MODE == 1) ? (pht_base ^ ghr) : pht_base;
  assign rd_ctr         = pht[pred_pht_index];
  assign ras_empty      = (ras_cnt == '0);

  assign wr_idx      = upd_pc[BI+1:2];
  assign upd_ctr     = pht[upd_pht_index];
  assign ras_top_inc = ras_top + 1'b1;
  assign ras_top_dec = ras_top - 1'b1;

  always_comb begin
    target_valid   = rd_hit;
    predict_taken  = 1'b0;
    predict_target = '0;
    if (rd_hit) begin
      predict_target = rd_entry.target;
      case (rd_entry.kind)
        T_BRANCH: predict_taken = rd_ctr[1];
        T_RET: begin
          predict_taken = 1'b1;
          if (!ras_empty) predict_target = ras[ras_top];
        end
        default:  predict_taken = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb[i].valid <= 1'b0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      ghr              <= '0;
      ras_top          <= '0;
      ras_cnt          <= '0;
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (upd_valid) begin
        if (upd_type == T_BRANCH) begin
          if (upd_taken && upd_ctr != 2'b11) pht[upd_pht_index] <= upd_ctr + 2'd1;
          else if (!upd_taken && upd_ctr != 2'b00) pht[upd_pht_index] <= upd_ctr - 2'd1;
          ghr <= {ghr[HIST_BITS-2:0], upd_taken};
          if (perf_branches != '1) perf_branches <= perf_branches + 32'd1;
        end
        // Not-taken outcomes never allocate and never disturb an existing entry.
        if (upd_taken) begin
          btb[wr_idx] <= '{valid: 1'b1, tag: upd_pc[XLEN-1:BI+2],
                           target: upd_target, kind: upd_type};
        end
        if (upd_mispredict && perf_mispredicts != '1)
          perf_mispredicts <= perf_mispredicts + 32'd1;
      end

      // Push+pop on a non-empty stack swaps the top in place; on an empty one it is a plain push.
      if (ras_push && ras_pop && !ras_empty) begin
        ras[ras_top] <= ras_push_addr;
      end else if (ras_push) begin
        ras_top          <= ras_top_inc;
        ras[ras_top_inc] <= ras_push_addr;
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
      end else if (ras_pop && !ras_empty) begin
        ras_top <= ras_top_dec;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench: bimodal instance (u_bim) and 4-bit-history gshare instance (u_gsh) share all stimulus.
module tb_branch_pred_unit;

  logic        clock;
  logic        reset;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [7:0]  upd_idx_a;
  logic [3:0]  upd_idx_b;
  logic        upd_mispredict;
  logic        ras_push;
  logic [31:0] ras_push_addr;
  logic        ras_pop;

  logic        a_taken, a_tv;
  logic [31:0] a_target, a_pbr, a_pmp;
  logic [7:0]  a_idx;
  logic        b_taken, b_tv;
  logic [31:0] b_target, b_pbr, b_pmp;
  logic [3:0]  b_idx;

  int errors = 0;
  int checks = 0;

  branch_pred_unit #(.MODE(0)) u_bim (
    .clock(clock), .reset(reset), .if_pc(if_pc),
    .predict_taken(a_taken), .predict_target(a_target), .target_valid(a_tv),
    .pred_pht_index(a_idx), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_type(upd_type), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pht_index(upd_idx_a), .upd_mispredict(upd_mispredict),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .perf_branches(a_pbr), .perf_mispredicts(a_pmp)
  );

  branch_pred_unit #(.MODE(1), .HIST_BITS(4)) u_gsh (
    .clock(clock), .reset(reset), .if_pc(if_pc),
    .predict_taken(b_taken), .predict_target(b_target), .target_valid(b_tv),
    .pred_pht_index(b_idx), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_type(upd_type), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pht_index(upd_idx_b), .upd_mispredict(upd_mispredict),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .perf_branches(b_pbr), .perf_mispredicts(b_pmp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs();
    if_pc = '0; upd_valid = 0; upd_pc = '0; upd_type = '0; upd_taken = 0;
    upd_target = '0; upd_idx_a = '0; upd_idx_b = '0; upd_mispredict = 0;
    ras_push = 0; ras_push_addr = '0; ras_pop = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic send_upd(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                          input logic [31:0] tgt, input logic [7:0] ia, input logic [3:0] ib,
                          input logic mp);
    upd_pc = pc; upd_type = ty; upd_taken = tk; upd_target = tgt;
    upd_idx_a = ia; upd_idx_b = ib; upd_mispredict = mp; upd_valid = 1;
    tick();
    upd_valid = 0; upd_mispredict = 0;
  endtask

  task automatic ras_op(input logic push, input logic pop, input logic [31:0] addr);
    ras_push = push; ras_pop = pop; ras_push_addr = addr;
    tick();
    ras_push = 0; ras_pop = 0;
  endtask

  // A pending update in the reset cycle must be dropped; then no PC may hit.
  task automatic test_reset();
    clr_inputs();
    reset = 1;
    upd_pc = 32'h10; upd_type = 2'b01; upd_taken = 1; upd_target = 32'h99;
    upd_mispredict = 1; upd_valid = 1;
    tick();
    tick();
    reset = 0; upd_valid = 0; upd_mispredict = 0;
    tick();
    for (int p = 0; p <= 32'h100; p += 4) begin
      logic [31:0] pc_v;
      pc_v = p;
      if_pc = pc_v;
      #1;
      checks++; if (a_tv !== 1'b0 || a_taken !== 1'b0 || a_target !== 32'h0) begin
        errors++; $display("FAIL reset_pred_bim pc=%h got tv=%b tk=%b tgt=%h exp 0/0/0", pc_v, a_tv, a_taken, a_target);
      end
      checks++; if (b_tv !== 1'b0 || b_taken !== 1'b0) begin
        errors++; $display("FAIL reset_pred_gsh pc=%h got tv=%b tk=%b exp 0/0", pc_v, b_tv, b_taken);
      end
      checks++; if (a_idx !== pc_v[9:2] || b_idx !== pc_v[5:2]) begin
        errors++; $display("FAIL reset_index pc=%h got %h/%h exp %h/%h", pc_v, a_idx, b_idx, pc_v[9:2], pc_v[5:2]);
      end
    end
    checks++; if (a_pbr !== 32'd0 || a_pmp !== 32'd0 || b_pbr !== 32'd0 || b_pmp !== 32'd0) begin
      errors++; $display("FAIL reset_perf got %0d %0d %0d %0d exp all 0", a_pbr, a_pmp, b_pbr, b_pmp);
    end
  endtask

  // Counter at index 0x10: 01 -> 10 -> 11 (sat) then down to 00 (sat).
  task automatic test_bimodal();
    do_reset();
    send_upd(32'h40, 2'b00, 1, 32'h80, 8'h10, 4'h0, 1);
    if_pc = 32'h40; #1;
    checks++; if (a_tv !== 1'b1 || a_taken !== 1'b1 || a_target !== 32'h80) begin
      errors++; $display("FAIL bim_first_taken got tv=%b tk=%b tgt=%h exp 1/1/80", a_tv, a_taken, a_target);
    end
    checks++; if (a_idx !== 8'h10) begin
      errors++; $display("FAIL bim_index got %h exp 10", a_idx);
    end
    for (int i = 0; i < 3; i++) send_upd(32'h40, 2'b00, 1, 32'h80, 8'h10, 4'h0, 0);
    send_upd(32'h40, 2'b00, 0, 32'h44, 8'h10, 4'h0, 1);
    if_pc = 32'h40; #1;
    checks++; if (a_taken !== 1'b1) begin
      errors++; $display("FAIL bim_sat_hi got tk=%b exp 1", a_taken);
    end
    for (int i = 0; i < 3; i++) send_upd(32'h40, 2'b00, 0, 32'h44, 8'h10, 4'h0, 0);
    if_pc = 32'h40; #1;
    checks++; if (a_taken !== 1'b0 || a_tv !== 1'b1 || a_target !== 32'h80) begin
      errors++; $display("FAIL bim_not_taken got tk=%b tv=%b tgt=%h exp 0/1/80", a_taken, a_tv, a_target);
    end
    send_upd(32'h40, 2'b00, 1, 32'h80, 8'h10, 4'h0, 0);
    if_pc = 32'h40; #1;
    checks++; if (a_taken !== 1'b0) begin
      errors++; $display("FAIL bim_sat_lo got tk=%b exp 0", a_taken);
    end
    checks++; if (a_pbr !== 32'd9 || a_pmp !== 32'd2) begin
      errors++; $display("FAIL bim_perf got br=%0d mp=%0d exp 9/2", a_pbr, a_pmp);
    end
  endtask

  // Alternating T/N at 0x40: mispredicts only at k=0,2,4, then the pattern is learned.
  task automatic test_gshare();
    logic [3:0] g;
    logic       outcome;
    do_reset();
    g = 4'h0;
    for (int k = 0; k < 32; k++) begin
      outcome = (k % 2 == 0);
      if_pc = 32'h40; #1;
      checks++; if (b_idx !== g) begin
        errors++; $display("FAIL gsh_index k=%0d got %h exp %h", k, b_idx, g);
      end
      if (k >= 24) begin
        checks++; if (b_taken !== outcome || b_tv !== 1'b1) begin
          errors++; $display("FAIL gsh_pred k=%0d got tk=%b tv=%b exp %b/1", k, b_taken, b_tv, outcome);
        end
      end
      send_upd(32'h40, 2'b00, outcome, 32'h80, 8'h10, g, (k < 5) && outcome);
      g = {g[2:0], outcome};
    end
    checks++; if (b_pbr !== 32'd32 || b_pmp !== 32'd3) begin
      errors++; $display("FAIL gsh_perf got br=%0d mp=%0d exp 32/3", b_pbr, b_pmp);
    end
  endtask

  // Five pushes into a 4-deep stack: 0x104 is overwritten by the wrap.
  task automatic test_ras();
    logic [31:0] exp_pop [5];
    exp_pop = '{32'h404, 32'h304, 32'h204, 32'h1234, 32'h1234};
    do_reset();
    send_upd(32'h900, 2'b11, 1, 32'h1234, 8'h0, 4'h0, 0);
    for (int i = 1; i <= 5; i++) ras_op(1, 0, i * 32'h100 + 32'h4);
    if_pc = 32'h900; #1;
    checks++; if (a_tv !== 1'b1 || a_taken !== 1'b1 || a_target !== 32'h504) begin
      errors++; $display("FAIL ras_top got tv=%b tk=%b tgt=%h exp 1/1/504", a_tv, a_taken, a_target);
    end
    for (int i = 0; i < 5; i++) begin
      ras_op(0, 1, 32'h0);
      #1;
      checks++; if (a_target !== exp_pop[i]) begin
        errors++; $display("FAIL ras_pop%0d got %h exp %h", i + 1, a_target, exp_pop[i]);
      end
    end
    ras_op(1, 0, 32'h704);
    #1;
    checks++; if (a_target !== 32'h704) begin
      errors++; $display("FAIL ras_push_after_empty got %h exp 704", a_target);
    end
    ras_op(0, 1, 32'h0);
    #1;
    checks++; if (a_target !== 32'h1234) begin
      errors++; $display("FAIL ras_underflow got %h exp 1234", a_target);
    end
  endtask

  // Continues from the empty stack left by test_ras (return entry at 0x900 still present).
  task automatic test_ras_simul();
    if_pc = 32'h900;
    ras_op(1, 0, 32'hB04);
    ras_op(1, 0, 32'hC04);
    ras_op(1, 1, 32'hA04);
    #1;
    checks++; if (a_target !== 32'hA04) begin
      errors++; $display("FAIL ras_swap_top got %h exp A04", a_target);
    end
    ras_op(0, 1, 32'h0);
    #1;
    checks++; if (a_target !== 32'hB04) begin
      errors++; $display("FAIL ras_swap_below got %h exp B04", a_target);
    end
    ras_op(0, 1, 32'h0);
    #1;
    checks++; if (a_target !== 32'h1234) begin
      errors++; $display("FAIL ras_swap_count got %h exp 1234", a_target);
    end
    ras_op(1, 1, 32'hA04);
    #1;
    checks++; if (a_target !== 32'hA04) begin
      errors++; $display("FAIL ras_swap_empty got %h exp A04", a_target);
    end
    ras_op(0, 1, 32'h0);
    #1;
    checks++; if (a_target !== 32'h1234) begin
      errors++; $display("FAIL ras_swap_empty_count got %h exp 1234", a_target);
    end
  endtask

  // 0x000 and 0x040 share BTB index 0; also same-cycle read-during-write.
  task automatic test_back_to_back();
    do_reset();
    send_upd(32'h000, 2'b01, 1, 32'h300, 8'h0, 4'h0, 1);
    if_pc = 32'h000; #1;
    checks++; if (a_tv !== 1'b1 || a_taken !== 1'b1 || a_target !== 32'h300) begin
      errors++; $display("FAIL alias_first got tv=%b tk=%b tgt=%h exp 1/1/300", a_tv, a_taken, a_target);
    end
    send_upd(32'h040, 2'b01, 1, 32'h500, 8'h0, 4'h0, 1);
    if_pc = 32'h000; #1;
    checks++; if (a_tv !== 1'b0 || a_taken !== 1'b0 || a_target !== 32'h0) begin
      errors++; $display("FAIL alias_evicted got tv=%b tk=%b tgt=%h exp 0/0/0", a_tv, a_taken, a_target);
    end
    if_pc = 32'h040; #1;
    checks++; if (a_tv !== 1'b1 || a_target !== 32'h500) begin
      errors++; $display("FAIL alias_second got tv=%b tgt=%h exp 1/500", a_tv, a_target);
    end
    upd_pc = 32'h040; upd_type = 2'b10; upd_taken = 1; upd_target = 32'h600;
    upd_mispredict = 1; upd_valid = 1;
    #1;
    checks++; if (a_target !== 32'h500) begin
      errors++; $display("FAIL rdw_old got %h exp 500", a_target);
    end
    tick();
    upd_valid = 0; upd_mispredict = 0;
    #1;
    checks++; if (a_target !== 32'h600 || a_taken !== 1'b1) begin
      errors++; $display("FAIL rdw_new got tgt=%h tk=%b exp 600/1", a_target, a_taken);
    end
    send_upd(32'h080, 2'b00, 0, 32'h84, 8'h20, 4'h0, 0);
    if_pc = 32'h080; #1;
    checks++; if (a_tv !== 1'b0) begin
      errors++; $display("FAIL nt_no_alloc got tv=%b exp 0", a_tv);
    end
    checks++; if (a_pbr !== 32'd1 || a_pmp !== 32'd3) begin
      errors++; $display("FAIL alias_perf got br=%0d mp=%0d exp 1/3", a_pbr, a_pmp);
    end
  endtask

  initial begin
    clr_inputs();
    reset = 1;
    test_reset();
    test_bimodal();
    test_gshare();
    test_ras();
    test_ras_simul();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
